// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM cycle scheduler: state encoding, bank geometry and
// refresh timing defaults.
package dram_pkg;

  localparam int unsigned NUM_BANKS             = 5;
  localparam int unsigned BANK_W                = 3;
  localparam int unsigned DEBT_W                = 3;
  localparam int unsigned DEF_RFSH_INTERVAL     = 109;
  localparam int unsigned DEF_PRECHARGE         = 1;
  localparam logic [DEBT_W-1:0] MAX_DEBT        = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StAccRow,
    StAccCol,
    StAccCas,
    StRfCas,
    StRfRas1,
    StRfRas2,
    StPre
  } dram_state_e;

  // Lowest set bit wins, so a malformed bank_sel can never select two rows.
  function automatic logic [BANK_W-1:0] bank_idx(input logic [NUM_BANKS-1:0] sel);
    logic [BANK_W-1:0] idx;
    idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (sel[i]) idx = BANK_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dram_rfsh_timer.sv
// Refresh interval timer with a saturating count of owed refreshes and a sticky overflow flag.
module dram_rfsh_timer
  import dram_pkg::*;
#(
  parameter int unsigned RFSH_INTERVAL = DEF_RFSH_INTERVAL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rfsh_done,
  output logic [DEBT_W-1:0] debt,
  output logic              debt_full,
  output logic              rfsh_overflow
);

  localparam int unsigned CntW = (RFSH_INTERVAL > 1) ? $clog2(RFSH_INTERVAL) : 1;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              ovf_q, ovf_d;
  logic              wrap;

  always_comb begin
    wrap   = (cnt_q == CntW'(RFSH_INTERVAL - 1));
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    debt_d = debt_q;
    ovf_d  = ovf_q;
    // A request and a completion in the same cycle cancel out.
    if (wrap && !rfsh_done) begin
      if (debt_q == MAX_DEBT) ovf_d = 1'b1;
      else                    debt_d = debt_q + 1'b1;
    end else if (rfsh_done && !wrap && debt_q != '0) begin
      debt_d = debt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign debt          = debt_q;
  assign debt_full     = (debt_q == MAX_DEBT);
  assign rfsh_overflow = ovf_q;

endmodule

// File: rtl/dram_cycle_scheduler.sv
// DRAM strobe sequencer: arbitrates CPU accesses against CAS-before-RAS refresh and drives
// registered RAS/CAS strobes and the row/column mux select.
module dram_cycle_scheduler
  import dram_pkg::*;
#(
  parameter int unsigned RFSH_INTERVAL = DEF_RFSH_INTERVAL,
  parameter int unsigned PRECHARGE     = DEF_PRECHARGE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 as_n,
  input  logic                 uds_n,
  input  logic                 lds_n,
  input  logic [NUM_BANKS-1:0] bank_sel,
  input  logic                 mem_sel,
  output logic [NUM_BANKS-1:0] ras_n,
  output logic                 lcas_n,
  output logic                 ucas_n,
  output logic                 mux_sel,
  output logic                 acc_stall,
  output logic                 rfsh_overflow
);

  localparam int unsigned PreW = (PRECHARGE > 1) ? $clog2(PRECHARGE) : 1;

  dram_state_e          state_q, state_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [BANK_W-1:0]    ptr_q, ptr_d;
  logic [PreW-1:0]      pre_cnt_q, pre_cnt_d;
  logic [NUM_BANKS-1:0] ras_d;
  logic                 lcas_d, ucas_d, mux_d, stall_d;
  logic [DEBT_W-1:0]    debt;
  logic                 debt_full;
  logic                 rfsh_done;
  logic                 acc_req;

  assign acc_req   = !as_n && mem_sel && (|bank_sel);
  assign rfsh_done = (state_q == StRfRas2);

  dram_rfsh_timer #(
    .RFSH_INTERVAL(RFSH_INTERVAL)
  ) u_rfsh_timer (
    .clk          (clk),
    .reset        (reset),
    .rfsh_done    (rfsh_done),
    .debt         (debt),
    .debt_full    (debt_full),
    .rfsh_overflow(rfsh_overflow)
  );

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    ptr_d     = ptr_q;
    pre_cnt_d = pre_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (debt_full) begin
          state_d = StRfCas;
        end else if (acc_req) begin
          state_d = StAccRow;
          bank_d  = bank_idx(bank_sel);
        end else if (debt != '0 && as_n) begin
          state_d = StRfCas;
        end
      end
      StAccRow: state_d = as_n ? StPre : StAccCol;
      StAccCol: state_d = as_n ? StPre : StAccCas;
      StAccCas: if (as_n) state_d = StPre;
      StRfCas:  state_d = StRfRas1;
      StRfRas1: state_d = StRfRas2;
      StRfRas2: begin
        state_d = StPre;
        ptr_d   = (ptr_q == BANK_W'(NUM_BANKS - 1)) ? '0 : ptr_q + 1'b1;
      end
      StPre: begin
        if (pre_cnt_q == PreW'(PRECHARGE - 1)) begin
          state_d   = StIdle;
          pre_cnt_d = '0;
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_comb begin
    ras_d  = '1;
    lcas_d = 1'b1;
    ucas_d = 1'b1;
    mux_d  = 1'b0;
    unique case (state_d)
      StAccRow, StAccCol, StAccCas: begin
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (BANK_W'(i) == bank_d) ras_d[i] = 1'b0;
        end
        mux_d = (state_d != StAccRow);
        if (state_d == StAccCas) begin
          lcas_d = lds_n;
          ucas_d = uds_n;
        end
      end
      StRfCas: begin
        lcas_d = 1'b0;
        ucas_d = 1'b0;
      end
      StRfRas1, StRfRas2: begin
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (BANK_W'(i) == ptr_q) ras_d[i] = 1'b0;
        end
        lcas_d = 1'b0;
        ucas_d = 1'b0;
      end
      default: ;
    endcase
    stall_d = acc_req && !(state_d inside {StAccRow, StAccCol, StAccCas});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      bank_q    <= '0;
      ptr_q     <= '0;
      pre_cnt_q <= '0;
      ras_n     <= '1;
      lcas_n    <= 1'b1;
      ucas_n    <= 1'b1;
      mux_sel   <= 1'b0;
      acc_stall <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      ptr_q     <= ptr_d;
      pre_cnt_q <= pre_cnt_d;
      ras_n     <= ras_d;
      lcas_n    <= lcas_d;
      ucas_n    <= ucas_d;
      mux_sel   <= mux_d;
      acc_stall <= stall_d;
    end
  end

endmodule

// File: tb/tb_dram_cycle_scheduler.sv
// Randomized bench for dram_cycle_scheduler against a cycle-phase reference model.
module tb_dram_cycle_scheduler;

  localparam int NB   = 5;
  localparam int RI   = 109;
  localparam int MAXD = 7;
  localparam int PRE  = 1;

  localparam int K_IDLE = 0;
  localparam int K_ACC  = 1;
  localparam int K_RF   = 2;
  localparam int K_PRE  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          as_n, uds_n, lds_n, mem_sel;
  logic [NB-1:0] bank_sel;
  logic [NB-1:0] ras_n;
  logic          lcas_n, ucas_n, mux_sel, acc_stall, rfsh_overflow;

  dram_cycle_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .as_n         (as_n),
    .uds_n        (uds_n),
    .lds_n        (lds_n),
    .bank_sel     (bank_sel),
    .mem_sel      (mem_sel),
    .ras_n        (ras_n),
    .lcas_n       (lcas_n),
    .ucas_n       (ucas_n),
    .mux_sel      (mux_sel),
    .acc_stall    (acc_stall),
    .rfsh_overflow(rfsh_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: activity kind plus cycles elapsed in it, debt and timer as integers.
  int            m_kind, m_age, m_bank, m_ptr, m_debt, m_tick, m_pre_left;
  bit            m_ovf, m_lcas, m_ucas, m_stall;
  logic [NB-1:0] e_ras;
  logic          e_l, e_u, e_mux;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_outputs();
    e_ras = '1;
    e_l   = 1'b1;
    e_u   = 1'b1;
    e_mux = 1'b0;
    if (m_kind == K_ACC) begin
      e_ras[m_bank] = 1'b0;
      if (m_age >= 1) e_mux = 1'b1;
      if (m_age >= 2) begin
        e_l = m_lcas;
        e_u = m_ucas;
      end
    end else if (m_kind == K_RF) begin
      e_l = 1'b0;
      e_u = 1'b0;
      if (m_age >= 1) e_ras[m_ptr] = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_kind = K_IDLE; m_age = 0; m_bank = 0; m_ptr = 0; m_debt = 0; m_tick = 0;
    m_pre_left = 0; m_ovf = 0; m_lcas = 1; m_ucas = 1; m_stall = 0;
    model_outputs();
  endtask

  task automatic model_step(input logic a, input logic u, input logic l,
                            input logic [NB-1:0] bs, input logic ms);
    bit wrap, done, valid;
    wrap  = (m_tick == RI - 1);
    done  = (m_kind == K_RF && m_age == 2);
    valid = !a && ms && (bs != '0);
    case (m_kind)
      K_IDLE: begin
        if (m_debt == MAXD) begin
          m_kind = K_RF; m_age = 0;
        end else if (valid) begin
          m_kind = K_ACC; m_age = 0; m_bank = lowest(bs);
        end else if (m_debt > 0 && a) begin
          m_kind = K_RF; m_age = 0;
        end
      end
      K_ACC: begin
        if (a) begin
          m_kind = K_PRE; m_pre_left = PRE;
        end else begin
          if (m_age < 2) m_age++;
          if (m_age == 2) begin
            m_lcas = l; m_ucas = u;
          end
        end
      end
      K_RF: begin
        if (m_age == 2) begin
          m_kind = K_PRE; m_pre_left = PRE; m_ptr = (m_ptr + 1) % NB;
        end else begin
          m_age++;
        end
      end
      default: begin
        m_pre_left--;
        if (m_pre_left == 0) m_kind = K_IDLE;
      end
    endcase
    if (wrap && !done) begin
      if (m_debt == MAXD) m_ovf = 1'b1;
      else                m_debt++;
    end else if (done && !wrap) begin
      m_debt--;
    end
    m_tick  = wrap ? 0 : m_tick + 1;
    m_stall = valid && (m_kind != K_ACC);
    model_outputs();
  endtask

  task automatic compare_all();
    check_val("ras_n", 32'(ras_n), 32'(e_ras));
    check_val("lcas_n", 32'(lcas_n), 32'(e_l));
    check_val("ucas_n", 32'(ucas_n), 32'(e_u));
    check_val("mux_sel", 32'(mux_sel), 32'(e_mux));
    check_val("acc_stall", 32'(acc_stall), 32'(m_stall));
    check_val("rfsh_overflow", 32'(rfsh_overflow), 32'(m_ovf));
  endtask

  // Called at a negedge: drive, advance the model past the next posedge, compare at next negedge.
  task automatic run_cycle(input logic a, input logic u, input logic l,
                           input logic [NB-1:0] bs, input logic ms);
    as_n = a; uds_n = u; lds_n = l; bank_sel = bs; mem_sel = ms;
    model_step(a, u, l, bs, ms);
    @(negedge clk);
    compare_all();
  endtask

  logic [NB-1:0] r_bs;
  logic          r_ms, r_u, r_l;
  int            r_lo, r_hi;

  initial begin
    reset = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; bank_sel = '0; mem_sel = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // Idle bus: three interval wraps produce refreshes on successive banks.
    repeat (3 * RI + 20) run_cycle(1'b1, 1'b1, 1'b1, '0, 1'b0);

    // Word read on bank 2, then a lower-byte write on bank 4.
    repeat (6) run_cycle(1'b0, 1'b0, 1'b0, 5'b00100, 1'b1);
    repeat (3) run_cycle(1'b1, 1'b1, 1'b1, '0, 1'b0);
    repeat (6) run_cycle(1'b0, 1'b1, 1'b0, 5'b10000, 1'b1);
    repeat (3) run_cycle(1'b1, 1'b1, 1'b1, '0, 1'b0);

    // Random bus traffic, including unselected and disabled cycles.
    for (int t = 0; t < 400; t++) begin
      r_bs = ($urandom_range(0, 9) == 0) ? '0 : NB'(1 << $urandom_range(0, NB - 1));
      r_ms = ($urandom_range(0, 7) != 0);
      r_u  = 1'($urandom_range(0, 1));
      r_l  = 1'($urandom_range(0, 1));
      r_lo = $urandom_range(1, 8);
      r_hi = $urandom_range(1, 4);
      repeat (r_lo) run_cycle(1'b0, r_u, r_l, r_bs, r_ms);
      repeat (r_hi) run_cycle(1'b1, 1'b1, 1'b1, '0, 1'b0);
    end

    // Back-to-back accesses leave no idle slot with as_n high, so debt saturates.
    for (int t = 0; t < 170; t++) begin
      repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 5'b00010, 1'b1);
      run_cycle(1'b1, 1'b1, 1'b1, '0, 1'b0);
    end
    repeat (2 * RI + 10) run_cycle(1'b0, 1'b0, 1'b1, 5'b01000, 1'b1);
    for (int t = 0; t < 30; t++) begin
      repeat (4) run_cycle(1'b0, 1'b1, 1'b0, 5'b00001, 1'b1);
      run_cycle(1'b1, 1'b1, 1'b1, '0, 1'b0);
    end

    // Drain debt, then start an access and reset it asynchronously in the CAS phase.
    repeat (80) run_cycle(1'b1, 1'b1, 1'b1, '0, 1'b0);
    repeat (5) run_cycle(1'b0, 1'b0, 1'b0, 5'b01000, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_ras_n", 32'(ras_n), 32'h1f);
    check_val("rst_lcas_n", 32'(lcas_n), 32'h1);
    check_val("rst_ucas_n", 32'(ucas_n), 32'h1);
    check_val("rst_mux_sel", 32'(mux_sel), 32'h0);
    @(negedge clk);
    compare_all();
    reset = 1'b1;

    // No bank selected: nothing strobes and no stall.
    repeat (20) run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    repeat (RI + 20) run_cycle(1'b1, 1'b1, 1'b1, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
